// File: rtl/acumulador_ula_pkg.sv
// Shared opcodes, Z-register control codes and FSM states for the
// operand-processing stage in front of the Z output register.
package acumulador_ula_pkg;

    localparam int ULA_WIDTH = 4;

    // Z register control codes; the Z register decodes the same values.
    localparam logic [3:0] TZ_CLEAR = 4'd0;
    localparam logic [3:0] TZ_LOAD  = 4'd1;
    localparam logic [3:0] TZ_HOLD  = 4'd2;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MUL   = 3'd5,
        OP_CLR   = 3'd6,
        OP_PASSA = 3'd7
    } ula_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MULT  = 2'd2,
        ST_WRITE = 2'd3
    } ula_state_e;

    function automatic logic [3:0] write_code(input ula_op_e op);
        return (op == OP_CLR) ? TZ_CLEAR : TZ_LOAD;
    endfunction

endpackage

// File: rtl/acumulador_ula_if.sv
// Request/result bundle between the operand source, this stage and the
// Z register. The master drives the request, the slave returns the result.
interface acumulador_ula_if
    import acumulador_ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
);
    logic             start;
    ula_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acumulador;
    logic [3:0]       tz;
    logic             busy;
    logic             done;
    logic             flag;

    modport master (
        output start, op, a, b,
        input  acumulador, tz, busy, done, flag
    );

    modport slave (
        input  start, op, a, b,
        output acumulador, tz, busy, done, flag
    );
endinterface

// File: rtl/acumulador_ula_mult_seq.sv
// LSB-first shift-add multiplier: the go edge performs iteration 0, the
// remaining WIDTH-1 iterations follow one per clock, fin pulses with the final product.
module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] prod,
    output logic               fin
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               fin_q, fin_d;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] partial;

    assign a_ext = {{WIDTH{1'b0}}, a};

    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_partial
            assign partial[gi] = mcand_q[gi] & mplier_q[0];
        end
    endgenerate

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        fin_d    = 1'b0;
        if (go) begin
            prod_d   = b[0] ? a_ext : '0;
            mcand_d  = a_ext << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            prod_d   = prod_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                fin_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
        end
    end

    assign busy = busy_q;
    assign prod = prod_q;
    assign fin  = fin_q;
endmodule

// File: rtl/acumulador_ula.sv
// Operand latch, single-cycle ALU and control FSM feeding the Z register.
// Handshake outputs are registered from the state, so the visible write cycle trails ST_WRITE by one clock.
module acumulador_ula
    import acumulador_ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    acumulador_ula_if.slave  bus
);
    ula_state_e       state_q, state_d;
    ula_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             flag_q, flag_d;
    logic [3:0]       tz_q, tz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               accept;
    logic               mul_go;
    logic               mul_busy;
    logic               mul_fin;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] and_w, or_w, xor_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;

    // busy_q also covers the visible write cycle, so a new request waits until it ends.
    assign accept = (state_q == ST_IDLE) && !busy_q && bus.start;
    assign mul_go = accept && (bus.op == OP_MUL);

    mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (mul_go),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .prod    (mul_prod),
        .fin     (mul_fin)
    );

    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_w[gi] = a_q[gi] & b_q[gi];
            assign or_w[gi]  = a_q[gi] | b_q[gi];
            assign xor_w[gi] = a_q[gi] ^ b_q[gi];
        end
    endgenerate

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res  = sum_w[WIDTH-1:0];
                alu_flag = sum_w[WIDTH];
            end
            OP_SUB: begin
                alu_res  = diff_w[WIDTH-1:0];
                alu_flag = diff_w[WIDTH];
            end
            OP_AND:   alu_res = and_w;
            OP_OR:    alu_res = or_w;
            OP_XOR:   alu_res = xor_w;
            OP_PASSA: alu_res = a_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        busy_d  = busy_q;
        tz_d    = TZ_HOLD;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    busy_d  = 1'b1;
                    state_d = (bus.op == OP_MUL) ? ST_MULT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = alu_res;
                flag_d  = alu_flag;
                state_d = ST_WRITE;
            end
            ST_MULT: begin
                if (mul_fin) begin
                    acc_d   = mul_prod[WIDTH-1:0];
                    flag_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d = ST_WRITE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; drop it rather than hang.
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                done_d  = 1'b1;
                tz_d    = write_code(op_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            tz_q    <= TZ_CLEAR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            tz_q    <= tz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.acumulador = acc_q;
    assign bus.flag       = flag_q;
    assign bus.tz         = tz_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_acumulador_ula.sv
// Directed bench for acumulador_ula: hand-computed results, latency,
// busy-ignore and asynchronous abort.
module tb_acumulador_ula;
    import acumulador_ula_pkg::*;

    localparam int W = ULA_WIDTH;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    acumulador_ula_if #(.WIDTH(W)) bus ();

    acumulador_ula #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic start_op(input ula_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        @(negedge clock);
    endtask

    task automatic run_op(input string tag, input ula_op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_acc,
                          input logic exp_flag, input logic [3:0] exp_tz, input int exp_lat);
        int lat = 0;
        bit busy_ok = 1'b1;
        start_op(op, a, b);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clock);
            if (bus.done) lat = i;
            if (!bus.busy) busy_ok = 1'b0;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/busy"}, busy_ok, 1);
        check({tag, "/acc"}, bus.acumulador, exp_acc);
        check({tag, "/flag"}, bus.flag, exp_flag);
        check({tag, "/tz"}, bus.tz, exp_tz);
        @(negedge clock);
        $display("op %0d a=%0h b=%0h -> acc=%0h flag=%0b lat=%0d", op, a, b, bus.acumulador, bus.flag, lat);
        check({tag, "/done_off"}, bus.done, 0);
        check({tag, "/tz_hold"}, bus.tz, TZ_HOLD);
        check({tag, "/busy_off"}, bus.busy, 0);
        check({tag, "/acc_kept"}, bus.acumulador, exp_acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [W-1:0] acc_seen;
        logic flag_seen;

        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clock);
        check("rst/acc", bus.acumulador, 0);
        check("rst/tz", bus.tz, TZ_CLEAR);
        check("rst/busy", bus.busy, 0);
        check("rst/done", bus.done, 0);
        check("rst/flag", bus.flag, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst/tz_after", bus.tz, TZ_HOLD);

        run_op("add_9_8",  OP_ADD,   4'h9, 4'h8, 4'h1, 1'b1, TZ_LOAD, 2);
        run_op("sub_3_5",  OP_SUB,   4'h3, 4'h5, 4'hE, 1'b1, TZ_LOAD, 2);
        run_op("sub_5_3",  OP_SUB,   4'h5, 4'h3, 4'h2, 1'b0, TZ_LOAD, 2);
        run_op("add_f_1",  OP_ADD,   4'hF, 4'h1, 4'h0, 1'b1, TZ_LOAD, 2);
        run_op("and_c_a",  OP_AND,   4'hC, 4'hA, 4'h8, 1'b0, TZ_LOAD, 2);
        run_op("or_c_a",   OP_OR,    4'hC, 4'hA, 4'hE, 1'b0, TZ_LOAD, 2);
        run_op("xor_c_a",  OP_XOR,   4'hC, 4'hA, 4'h6, 1'b0, TZ_LOAD, 2);
        run_op("mul_3_5",  OP_MUL,   4'h3, 4'h5, 4'hF, 1'b0, TZ_LOAD, 5);
        run_op("mul_3_6",  OP_MUL,   4'h3, 4'h6, 4'h2, 1'b1, TZ_LOAD, 5);
        run_op("mul_f_f",  OP_MUL,   4'hF, 4'hF, 4'h1, 1'b1, TZ_LOAD, 5);
        run_op("passa_7",  OP_PASSA, 4'h7, 4'h3, 4'h7, 1'b0, TZ_LOAD, 2);
        run_op("clr",      OP_CLR,   4'h5, 4'h9, 4'h0, 1'b0, TZ_CLEAR, 2);

        // A second request during a running multiply must be dropped.
        start_op(OP_MUL, 4'h2, 4'h2);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 4'h1;
        bus.b     = 4'h1;
        @(negedge clock);
        bus.start = 1'b0;
        dones     = 0;
        acc_seen  = '0;
        flag_seen = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (bus.done) begin
                dones++;
                acc_seen  = bus.acumulador;
                flag_seen = bus.flag;
            end
        end
        $display("ignore test: dones=%0d acc=%0h flag=%0b", dones, acc_seen, flag_seen);
        check("ignore/dones", dones, 1);
        check("ignore/acc", acc_seen, 4'h4);
        check("ignore/flag", flag_seen, 0);
        check("ignore/busy_off", bus.busy, 0);

        // Abort a multiply mid-iteration with the asynchronous reset.
        start_op(OP_MUL, 4'h3, 4'h5);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        $display("abort: acc=%0h tz=%0h busy=%0b", bus.acumulador, bus.tz, bus.busy);
        check("abort/acc", bus.acumulador, 0);
        check("abort/tz", bus.tz, TZ_CLEAR);
        check("abort/busy", bus.busy, 0);
        check("abort/done", bus.done, 0);
        check("abort/flag", bus.flag, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort/tz_after", bus.tz, TZ_HOLD);
        check("abort/busy_after", bus.busy, 0);
        run_op("add_2_2", OP_ADD, 4'h2, 4'h2, 4'h4, 1'b0, TZ_LOAD, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
